branch_predictor: RTL and testbench

- Fetch-stage branch predictor with a direct-mapped branch target buffer (BTB) and a 2-bit saturating counter per entry.
- Predicts next-PC for the fetch PC combinationally.
- Trains from the Execute stage using the resolved branch outcome, i.e. PCWrite from the conditional-logic stage and the ALU-computed target.
- Flags mispredictions and supplies the corrected PC to the PC mux and the hazard/flush logic.

---
 rtl/branch_predictor.sv | 119 +++++++++++
 tb/tb_branch_predictor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Zero-latency prediction and misprediction; training and perf counters update on the rising edge.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCF,
  output logic              PredTakenF,
  output logic [ADDR_W-1:0] PredTargetF,
  input  logic              ValidE,
  input  logic              BranchE,
  input  logic [ADDR_W-1:0] PCE,
  input  logic              PredTakenE,
  input  logic [ADDR_W-1:0] PredTargetE,
  input  logic              TakenE,
  input  logic [ADDR_W-1:0] TargetE,
  output logic              MispredictE,
  output logic [ADDR_W-1:0] RedirectPCE,
  output logic [CNT_W-1:0]  BranchCnt,
  output logic [CNT_W-1:0]  MissCnt
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]  w_idx_f;
  logic [TAG_W-1:0]  w_tag_f;
  logic              w_hit_f;
  logic [ADDR_W-1:0] w_pcf_inc;
  logic [IDX_W-1:0]  w_idx_e;
  logic [TAG_W-1:0]  w_tag_e;
  logic              w_hit_e;
  logic [ADDR_W-1:0] w_pce_inc;
  logic              w_resolve;
  logic              w_stale;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Prediction reads pre-write contents; a same-cycle update becomes visible next cycle.
  assign w_idx_f     = PCF[IDX_W+1:2];
  assign w_tag_f     = PCF[ADDR_W-1:IDX_W+2];
  assign w_pcf_inc   = PCF + ADDR_W'(4);
  assign w_hit_f     = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign PredTakenF  = w_hit_f && r_ctr[w_idx_f][1];
  assign PredTargetF = PredTakenF ? r_target[w_idx_f] : w_pcf_inc;

  assign w_idx_e   = PCE[IDX_W+1:2];
  assign w_tag_e   = PCE[ADDR_W-1:IDX_W+2];
  assign w_pce_inc = PCE + ADDR_W'(4);
  assign w_hit_e   = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
  assign w_resolve = ValidE && BranchE;
  assign w_stale   = ValidE && !BranchE && PredTakenE;

  always_comb begin
    MispredictE = 1'b0;
    RedirectPCE = w_pce_inc;
    if (w_resolve) begin
      MispredictE = (PredTakenE != TakenE) ||
                    (TakenE && PredTakenE && (PredTargetE != TargetE));
      RedirectPCE = TakenE ? TargetE : w_pce_inc;
    end else if (w_stale) begin
      MispredictE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_resolve) begin
      if (w_hit_e) begin
        r_ctr[w_idx_e] <= TakenE ? sat_inc(r_ctr[w_idx_e]) : sat_dec(r_ctr[w_idx_e]);
        if (TakenE) r_target[w_idx_e] <= TargetE;
      end else if (TakenE) begin
        // Not-taken misses are never allocated, so only taken branches displace an entry.
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= TargetE;
        r_ctr[w_idx_e]    <= 2'b10;
      end
    end else if (w_stale && w_hit_e) begin
      r_valid[w_idx_e] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_resolve && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (MispredictE && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign BranchCnt = r_branch_cnt;
  assign MissCnt   = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; counters built 4 bits wide so saturation is reachable.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCF = 32'h0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        ValidE = 1'b0;
  logic        BranchE = 1'b0;
  logic [31:0] PCE = 32'h0;
  logic        PredTakenE = 1'b0;
  logic [31:0] PredTargetE = 32'h0;
  logic        TakenE = 1'b0;
  logic [31:0] TargetE = 32'h0;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [3:0]  BranchCnt;
  logic [3:0]  MissCnt;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.ENTRIES(16), .IDX_W(4), .ADDR_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .ValidE(ValidE), .BranchE(BranchE), .PCE(PCE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .TakenE(TakenE), .TargetE(TargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic v, input logic b, input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptgt, input logic t, input logic [31:0] tgt);
    ValidE = v; BranchE = b; PCE = pc; PredTakenE = pt;
    PredTargetE = ptgt; TakenE = t; TargetE = tgt;
    #1;
  endtask

  task automatic idle_e();
    drive_e(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic taken,
                      input logic [31:0] tgt);
    PCF = pc;
    #1;
    check({tag, ".taken"}, {31'b0, PredTakenF}, {31'b0, taken});
    check({tag, ".target"}, PredTargetF, tgt);
  endtask

  task automatic resolve(input string tag, input logic b, input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptgt, input logic t, input logic [31:0] tgt,
                         input logic misp, input logic [31:0] redir);
    drive_e(1'b1, b, pc, pt, ptgt, t, tgt);
    check({tag, ".misp"}, {31'b0, MispredictE}, {31'b0, misp});
    check({tag, ".redir"}, RedirectPCE, redir);
    tick();
    idle_e();
  endtask

  task automatic counts(input string tag, input int br, input int ms);
    check({tag, ".branch_cnt"}, {28'b0, BranchCnt}, br);
    check({tag, ".miss_cnt"}, {28'b0, MissCnt}, ms);
  endtask

  initial begin
    // Case 1: reset state
    #2;
    pred("rst", 32'h100, 1'b0, 32'h104);
    counts("rst", 0, 0);
    tick();
    rst = 1'b1;
    tick();

    // Case 2: first taken branch allocates; same-cycle fetch sees pre-write contents
    PCF = 32'h100;
    drive_e(1'b1, 1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h200);
    check("c2.nobypass", {31'b0, PredTakenF}, 32'h0);
    check("c2.misp", {31'b0, MispredictE}, 32'h1);
    check("c2.redir", RedirectPCE, 32'h200);
    tick();
    idle_e();
    pred("c2.after", 32'h100, 1'b1, 32'h200);
    counts("c2", 1, 1);

    // Case 3: saturate up, then two not-taken to drop below threshold
    for (int i = 0; i < 3; i++)
      resolve("c3.up", 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    counts("c3.up", 4, 1);
    resolve("c3.nt1", 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h104);
    pred("c3.nt1", 32'h100, 1'b1, 32'h200);
    resolve("c3.nt2", 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h104);
    pred("c3.nt2", 32'h100, 1'b0, 32'h104);
    counts("c3", 6, 3);

    // Case 4: aliasing at idx 0
    pred("c4.alias", 32'h140, 1'b0, 32'h144);
    resolve("c4.alloc", 1'b1, 32'h140, 1'b0, 32'h144, 1'b1, 32'h300, 1'b1, 32'h300);
    pred("c4.new", 32'h140, 1'b1, 32'h300);
    pred("c4.old", 32'h100, 1'b0, 32'h104);
    counts("c4", 7, 4);

    // Case 5: wrong target on a hit
    resolve("c5.alloc", 1'b1, 32'h104, 1'b0, 32'h108, 1'b1, 32'h200, 1'b1, 32'h200);
    resolve("c5.wrong", 1'b1, 32'h104, 1'b1, 32'h200, 1'b1, 32'h280, 1'b1, 32'h280);
    pred("c5.after", 32'h104, 1'b1, 32'h280);
    counts("c5", 9, 6);

    // Non-branch predicted taken: mispredict and entry invalidated
    resolve("stale", 1'b0, 32'h104, 1'b1, 32'h280, 1'b0, 32'h0, 1'b1, 32'h108);
    pred("stale.after", 32'h104, 1'b0, 32'h108);
    counts("stale", 9, 7);

    // Bubble carrying BranchE: no mispredict, no update, no count
    drive_e(1'b0, 1'b1, 32'h140, 1'b0, 32'h144, 1'b1, 32'h500);
    check("bubble.misp", {31'b0, MispredictE}, 32'h0);
    tick();
    idle_e();
    pred("bubble.after", 32'h140, 1'b1, 32'h300);
    counts("bubble", 9, 7);

    // PC+4 wraps
    pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Case 6: asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    rst = 1'b0;
    pred("c6.rst", 32'h140, 1'b0, 32'h144);
    counts("c6.rst", 0, 0);
    tick();
    rst = 1'b1;
    #2;
    resolve("c6.retrain", 1'b1, 32'h140, 1'b0, 32'h144, 1'b1, 32'h300, 1'b1, 32'h300);
    pred("c6.retrain", 32'h140, 1'b1, 32'h300);
    counts("c6", 1, 1);

    // Performance counters saturate at all-ones
    for (int i = 0; i < 20; i++) begin
      drive_e(1'b1, 1'b1, 32'h140, 1'b0, 32'h144, 1'b1, 32'h300);
      tick();
    end
    idle_e();
    counts("sat", 15, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
